// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file.
// RF_BYPASS_EN (optional macro) selects write-first collision handling in rf_read_port.
package rf_pkg;

  localparam int RF_WIDTH   = 32;
  localparam int RF_DEPTH   = 32;
  localparam int RF_NREAD   = 2;
  localparam int RF_BUS_MAX = 256;

  function automatic int rf_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Extract field idx of width w from a flattened bus (low field at bit 0).
  function automatic logic [RF_BUS_MAX-1:0] rf_field(input logic [RF_BUS_MAX-1:0] bus,
                                                    input int idx, input int w);
    logic [RF_BUS_MAX-1:0] mask;
    mask = {RF_BUS_MAX{1'b1}} >> (RF_BUS_MAX - w);
    return (bus >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: address mux, optional write-first bypass, hold-on-disable flops.
// RF_BYPASS_EN defined: same-edge write to the read address is forwarded to rdata.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int AW       = rf_aw(RF_DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [WIDTH-1:0] i_mem [DEPTH],
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_rvalid
);

  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;
  logic             w_hit;
  logic             w_zero;
  logic [WIDTH-1:0] w_next;

`ifdef RF_BYPASS_EN
  assign w_hit = i_we && (i_waddr == i_raddr);
`else
  logic w_unused_bypass;
  assign w_unused_bypass = ^{i_we, i_waddr};
  assign w_hit = 1'b0;
`endif

  assign w_zero = (ZERO_REG != 0) && (i_raddr == '0);

  // $zero wins over the bypass so a dropped write can never leak out.
  always_comb begin
    w_next = i_mem[i_raddr];
    if (w_zero)     w_next = '0;
    else if (w_hit) w_next = i_wdata;
  end

  // re is a one-cycle request with no back-pressure; rvalid pulses the next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= i_re;
      if (i_re) r_rdata <= w_next;
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port MIPS register file: storage array, write decode and NREAD registered read ports.
// Optional macro RF_BYPASS_EN: write-first on read/write collision (default read-first).
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NREAD    = RF_NREAD,
  parameter int ZERO_REG = 1,
  localparam int AW      = rf_aw(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [NREAD-1:0]       re,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] rdata,
  output logic [NREAD-1:0]       rvalid
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr_en;

  assign w_wr_en = we && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (w_wr_en) begin
      r_mem[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0]    w_raddr;
    logic [WIDTH-1:0] w_rdata;

    assign w_raddr = AW'(rf_field(RF_BUS_MAX'(raddr), g, AW));

    rf_read_port #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG)
    ) u_port (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_re    (re[g]),
      .i_raddr (w_raddr),
      .i_we    (we),
      .i_waddr (waddr),
      .i_wdata (wdata),
      .i_mem   (r_mem),
      .o_rdata (w_rdata),
      .o_rvalid(rvalid[g])
    );

    assign rdata[g*WIDTH +: WIDTH] = w_rdata;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp (WIDTH=32, DEPTH=32, NREAD=2) plus a short model-checked random run.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rvalid;

  int total = 0;
  int bad   = 0;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [31:0] model [32];
  logic [31:0] exp_d [2];
  logic        exp_v [2];

  always #5 clk = ~clk;

  reg_file_mp dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with a write and reads pending: reset must win.
    rst_n = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hFFFF_FFFF;
    re = 2'b11; raddr = {5'd5, 5'd5};
    tick();
    chk("rst_rdata0_c1", rdata[31:0], 32'h0);
    chk("rst_rvalid_c1", {30'h0, rvalid}, 32'h0);
    tick();
    chk("rst_rdata0", rdata[31:0], 32'h0);
    chk("rst_rdata1", rdata[63:32], 32'h0);
    chk("rst_rvalid", {30'h0, rvalid}, 32'h0);

    // Every word reads back 0 after reset.
    rst_n = 1'b1; we = 1'b0;
    for (int a = 0; a < 32; a += 2) begin
      re = 2'b11; raddr = {5'(a + 1), 5'(a)};
      tick();
      chk("rst_word_p0", rdata[31:0], 32'h0);
      chk("rst_word_p1", rdata[63:32], 32'h0);
    end
    chk("rst_word_rvalid", {30'h0, rvalid}, 32'h3);

    // Basic write then read on port 0.
    re = 2'b00; we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    tick();
    chk("idle_rvalid", {30'h0, rvalid}, 32'h0);
    we = 1'b0; re = 2'b01; raddr = {5'd0, 5'd5};
    tick();
    chk("wr_rd_data", rdata[31:0], 32'hDEAD_BEEF);
    chk("wr_rd_valid", {30'h0, rvalid}, 32'h1);

    // Zero register ignores writes.
    re = 2'b00; we = 1'b1; waddr = 5'd0; wdata = 32'h1234_5678;
    tick();
    we = 1'b0; re = 2'b11; raddr = {5'd0, 5'd0};
    tick();
    chk("zero_p0", rdata[31:0], 32'h0);
    chk("zero_p1", rdata[63:32], 32'h0);
    chk("zero_valid", {30'h0, rvalid}, 32'h3);

    // Hold on disable.
    re = 2'b01; raddr = {5'd0, 5'd5};
    tick();
    chk("hold_pre", rdata[31:0], 32'hDEAD_BEEF);
    re = 2'b00; we = 1'b1; waddr = 5'd5; wdata = 32'h1;
    tick();
    chk("hold_data", rdata[31:0], 32'hDEAD_BEEF);
    chk("hold_valid", {30'h0, rvalid}, 32'h0);
    we = 1'b0; re = 2'b01;
    tick();
    chk("hold_newval", rdata[31:0], 32'h1);

    // Collision on addr 7.
    we = 1'b1; waddr = 5'd7; wdata = 32'hA; re = 2'b00;
    tick();
    wdata = 32'hB; re = 2'b01; raddr = {5'd0, 5'd7};
    tick();
    chk("collide", rdata[31:0], BYP ? 32'hB : 32'hA);
    we = 1'b0;
    tick();
    chk("collide_next", rdata[31:0], 32'hB);

    // Collision at address 0: $zero still wins.
    we = 1'b1; waddr = 5'd0; wdata = 32'hCAFE; re = 2'b10; raddr = {5'd0, 5'd7};
    tick();
    chk("collide_zero", rdata[63:32], 32'h0);

    // Independent ports, different addresses, same address.
    we = 1'b1; waddr = 5'd31; wdata = 32'h5A5A_0031; re = 2'b00;
    tick();
    we = 1'b0; re = 2'b11; raddr = {5'd31, 5'd7};
    tick();
    chk("dual_p0", rdata[31:0], 32'hB);
    chk("dual_p1", rdata[63:32], 32'h5A5A_0031);
    raddr = {5'd31, 5'd31};
    tick();
    chk("same_p0", rdata[31:0], 32'h5A5A_0031);
    chk("same_p1", rdata[63:32], 32'h5A5A_0031);

    // Random run against a behavioural model, with resets at the start and midway.
    exp_d[0] = rdata[31:0]; exp_d[1] = rdata[63:32];
    exp_v[0] = 1'b0; exp_v[1] = 1'b0;
    for (int i = 0; i < 200; i++) begin
      rst_n = (i == 0 || i == 100) ? 1'b0 : 1'b1;
      we    = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 7));
      wdata = $urandom;
      re    = 2'($urandom_range(0, 3));
      raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      for (int p = 0; p < 2; p++) begin
        logic [4:0] a;
        a = raddr[p*5 +: 5];
        if (!rst_n) begin
          exp_d[p] = 32'h0; exp_v[p] = 1'b0;
        end else if (re[p]) begin
          exp_v[p] = 1'b1;
          if (a == 5'd0)                       exp_d[p] = 32'h0;
          else if (BYP && we && waddr == a)    exp_d[p] = wdata;
          else                                 exp_d[p] = model[a];
        end else begin
          exp_v[p] = 1'b0;
        end
      end
      if (!rst_n) begin
        for (int k = 0; k < 32; k++) model[k] = 32'h0;
      end else if (we && waddr != 5'd0) begin
        model[waddr] = wdata;
      end
      tick();
      chk("rnd_p0", rdata[31:0], exp_d[0]);
      chk("rnd_p1", rdata[63:32], exp_d[1]);
      chk("rnd_v0", {31'h0, rvalid[0]}, {31'h0, exp_v[0]});
      chk("rnd_v1", {31'h0, rvalid[1]}, {31'h0, exp_v[1]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
